bcd_cnt_scan: RTL
=================

Name: bcd_cnt_scan

Overview:
4-digit BCD up/down counter with integrated display-scan sequencer. It sits directly upstream of the seven-segment scan multiplexer and drives its 2-bit scan select plus the four digit values (dig3 = most significant, dig0 = least significant). Counting is paced by an internal tick divider, so the counter can be driven from the board clock.

Parameters:
CNT_TICK, 100000000, clk cycles per count step (1 Hz at 100 MHz); legal range >= 2.
SCAN_TICK, 100000, clk cycles per scan-select advance (1 kHz per digit at 100 MHz); legal range >= 2.

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous reset, active-low
en  in  1  count enable; 0 pauses counting only
up_dn  in  1  1 = count up, 0 = count down
clr  in  1  synchronous clear of count and tick divider
load  in  1  synchronous load of load_val
load_val  in  16  BCD value {d3,d2,d1,d0}
ssd_ctl_en  out  2  scan select to display mux
dig3, dig2, dig1, dig0  out  4 each  BCD digits
wrap  out  1  one-cycle pulse on 9999->0000 (up) or 0000->9999 (down)

Behaviour:
- Reset: one clock; reset is synchronous and active-low (clk, rst_n). While rst_n = 0 at a rising edge, all of the following clear to 0: dig3..dig0, ssd_ctl_en, wrap, tick divider, and scan divider.
- All outputs are registered; there is no combinational path from any input to any output.
- Priority at each edge: rst_n low > clr > load > count step.
- Tick divider, tick_cnt (0..CNT_TICK-1):
  - Increments only when en = 1.
  - At CNT_TICK-1 it wraps to 0 and raises an internal step on that same edge.
  - en = 0 holds tick_cnt, so pause and resume keeps the phase.
- Step, up: the digit chain increments with per-digit carry (9 -> 0 carries into the next digit). 9999 -> 0000 sets wrap = 1 for exactly one cycle.
- Step, down: the digit chain decrements with per-digit borrow (0 -> 9 borrows from the next digit). 0000 -> 9999 sets wrap = 1 for exactly one cycle.
- up_dn is sampled on the step edge only. A direction change between steps takes effect at the next step.
- clr:
  - Digits go to 0000 and tick_cnt goes to 0; wrap = 0.
  - The scan divider and ssd_ctl_en are not affected.
- load:
  - Digits take load_val and tick_cnt goes to 0; wrap = 0.
  - Any load nibble > 9 is clamped to 9 in that digit.
  - A load overrides a coincident step.
- wrap is otherwise 0 and never lasts more than one cycle.
- Scan sequencer:
  - scan_cnt (0..SCAN_TICK-1) is free-running and independent of en, clr and load.
  - At SCAN_TICK-1, ssd_ctl_en advances 00 -> 01 -> 10 -> 11 -> 00.
  - ssd_ctl_en is reset only by rst_n.
- Digit values may change at any point in the scan cycle. No synchronisation to the scan is required, because the downstream mux is purely combinational.
- Reset asserted mid-step or mid-load: reset wins and every register clears on that edge.

Decomposition:
- Shared package:
  - BCD_W = 4, BCD_MAX = 4'd9, SCAN_W = 2.
  - The scan-select encoding constants (SCAN_D3 = 2'b00 through SCAN_D0 = 2'b11), shared with the display mux.
- Natural sub-module: bcd_digit.
  - Ports: clk, rst_n, clr, load, load_d, step_in (carry/borrow in), up_dn, q[3:0], step_out.
  - step_out is combinational: asserted when step_in is high and q = 9 (up) or q = 0 (down).
  - Four instances are chained d0 -> d3. wrap is registered from d3's step_out.
- Tick and scan dividers are inline counters in the top module.

Test Plan (bench uses CNT_TICK = 4, SCAN_TICK = 2):
1. Reset release with en = 0 for 20 cycles -> digits stay 0000, wrap = 0; ssd_ctl_en steps 00, 01, 10, 11, 00 with a change every 2 cycles.
2. en = 1, up_dn = 1 from 0000 -> one increment every 4 cycles; after 10 steps the digits read 0010. Load 0999 and take one step -> 1000, wrap stays 0.
3. Load 9999, up_dn = 1, one step -> 0000 and wrap high for exactly 1 cycle. Load 0000, up_dn = 0, one step -> 9999 and wrap high for 1 cycle.
4. load_val = 16'hA5F3 -> digits 9, 5, 9, 3. Assert clr and load in the same cycle -> 0000 (clr wins). Assert load coincident with a step edge -> the loaded value, no increment.
5. Pause: en = 1 for 2 cycles, en = 0 for 10 cycles, then en = 1 -> the next step occurs 2 enabled cycles later (phase held), and ssd_ctl_en keeps scanning throughout.
6. Drive rst_n = 0 for one edge at count 1234 mid-period -> digits 0000, ssd_ctl_en 00, wrap 0 on that edge; the first step after release comes 4 enabled cycles later.

Source files
------------

// File: rtl/bcd_cnt_scan_pkg.sv
// -----------------------------------------------------------------------------
// bcd_cnt_scan_pkg
// Shared constants and helpers for the BCD counter / display-scan block.
//   BCD_W    : width of one BCD digit
//   BCD_MAX  : largest legal BCD digit value
//   SCAN_W   : width of the scan select driven to the display mux
//   SCAN_D*  : scan-select encoding, common with the display mux
//   clamp_bcd: saturates an out-of-range nibble to BCD_MAX
// -----------------------------------------------------------------------------
package bcd_cnt_scan_pkg;

   localparam int             BCD_W   = 4;
   localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;
   localparam int             SCAN_W  = 2;

   // Scan-select encoding: 00 selects the most significant digit.
   localparam logic [SCAN_W-1:0] SCAN_D3 = 2'b00;
   localparam logic [SCAN_W-1:0] SCAN_D2 = 2'b01;
   localparam logic [SCAN_W-1:0] SCAN_D1 = 2'b10;
   localparam logic [SCAN_W-1:0] SCAN_D0 = 2'b11;

   function automatic logic [BCD_W-1:0] clamp_bcd(input logic [BCD_W-1:0] d);
      return (d > BCD_MAX) ? BCD_MAX : d;
   endfunction

endpackage

// File: rtl/bcd_cnt_scan_digit.sv
// -----------------------------------------------------------------------------
// bcd_digit
// One decade of the BCD up/down counter chain.
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : synchronous clear to 0
//   load       : synchronous load of load_d (clamped to 9)
//   load_d     : digit value to load
//   step_in    : carry (up) or borrow (down) from the lower digit
//   up_dn      : 1 = count up, 0 = count down
//   q          : registered digit value
//   step_out   : combinational carry/borrow to the next higher digit
// -----------------------------------------------------------------------------
module bcd_digit
   import bcd_cnt_scan_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             load,
   input  logic [BCD_W-1:0] load_d,
   input  logic             step_in,
   input  logic             up_dn,
   output logic [BCD_W-1:0] q,
   output logic             step_out
);

   logic at_limit;

   // The digit rolls over when it sits at 9 going up or at 0 going down.
   assign at_limit = up_dn ? (q == BCD_MAX) : (q == '0);
   assign step_out = step_in & at_limit;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (load) begin
         q <= clamp_bcd(load_d);
      end else if (step_in) begin
         if (up_dn) begin
            q <= at_limit ? '0 : q + BCD_W'(1);
         end else begin
            q <= at_limit ? BCD_MAX : q - BCD_W'(1);
         end
      end
   end

endmodule

// File: rtl/bcd_cnt_scan.sv
// -----------------------------------------------------------------------------
// bcd_cnt_scan
// 4-digit BCD up/down counter with a free-running display scan sequencer.
//   CNT_TICK   : clk cycles per count step (>= 2)
//   SCAN_TICK  : clk cycles per scan-select advance (>= 2)
//   clk, rst_n : clock, synchronous active-low reset
//   en         : count enable (pauses the tick divider, keeps its phase)
//   up_dn      : 1 = up, 0 = down; only matters on a step edge
//   clr        : clear digits and tick divider
//   load       : load load_val (each nibble clamped to 9), clear tick divider
//   load_val   : {d3,d2,d1,d0}
//   ssd_ctl_en : scan select to the display mux
//   dig3..dig0 : registered BCD digits, dig3 most significant
//   wrap       : one-cycle pulse on 9999->0000 or 0000->9999
// Priority per edge: rst_n > clr > load > count step.
// -----------------------------------------------------------------------------
module bcd_cnt_scan
   import bcd_cnt_scan_pkg::*;
#(
   parameter int CNT_TICK  = 100000000,
   parameter int SCAN_TICK = 100000
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              up_dn,
   input  logic              clr,
   input  logic              load,
   input  logic [15:0]       load_val,
   output logic [SCAN_W-1:0] ssd_ctl_en,
   output logic [BCD_W-1:0]  dig3,
   output logic [BCD_W-1:0]  dig2,
   output logic [BCD_W-1:0]  dig1,
   output logic [BCD_W-1:0]  dig0,
   output logic              wrap
);

   localparam int TICK_W = $clog2(CNT_TICK);
   localparam int SCAN_CW = $clog2(SCAN_TICK);

   logic [TICK_W-1:0]  tick_cnt;
   logic [SCAN_CW-1:0] scan_cnt;
   logic               tick_last;
   logic               scan_last;
   logic               step;
   logic [4:0]         carry;
   logic [BCD_W-1:0]   q_arr [4];

   assign tick_last = (tick_cnt == TICK_W'(CNT_TICK - 1));
   assign scan_last = (scan_cnt == SCAN_CW'(SCAN_TICK - 1));
   assign step      = en & tick_last;

   // Tick divider: held while en = 0 so a pause keeps the step phase.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tick_cnt <= '0;
      end else if (clr || load) begin
         tick_cnt <= '0;
      end else if (en) begin
         tick_cnt <= tick_last ? '0 : tick_cnt + TICK_W'(1);
      end
   end

   // Scan divider and select: only rst_n touches them.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         scan_cnt   <= '0;
         ssd_ctl_en <= SCAN_D3;
      end else if (scan_last) begin
         scan_cnt   <= '0;
         ssd_ctl_en <= ssd_ctl_en + SCAN_W'(1);
      end else begin
         scan_cnt   <= scan_cnt + SCAN_CW'(1);
      end
   end

   // Digit chain d0 -> d3; carry[i] is the step into digit i.
   assign carry[0] = step;

   for (genvar i = 0; i < 4; i++) begin : g_digit
      bcd_digit u_digit (
         .clk      (clk),
         .rst_n    (rst_n),
         .clr      (clr),
         .load     (load),
         .load_d   (load_val[i*BCD_W +: BCD_W]),
         .step_in  (carry[i]),
         .up_dn    (up_dn),
         .q        (q_arr[i]),
         .step_out (carry[i+1])
      );
   end

   assign dig0 = q_arr[0];
   assign dig1 = q_arr[1];
   assign dig2 = q_arr[2];
   assign dig3 = q_arr[3];

   // A carry out of d3 means the whole chain rolled over on this edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wrap <= 1'b0;
      end else if (clr || load) begin
         wrap <= 1'b0;
      end else begin
         wrap <= carry[4];
      end
   end

endmodule
